pipe_stage_reg_ctl: RTL and testbench

- Parametrised pipeline stage register, next generation of the plain stall/busy-gated pipe register.
- Adds a valid bit, a flush (kill), explicit bubble (NOP) insertion, a configurable busy mask and a configurable NOP/reset payload.
- Adds saturating per-stage event counters for stall, bubble and flush cycles.
- Instantiated between every CPU pipeline pair (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_stage_reg_ctl.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline constants: NOP encoding, default widths and the mul/div busy-bit layout.
package cpu_pipe_pkg;

  localparam int unsigned INSN_W     = 32;
  localparam int unsigned BUSY_W_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 16;

  // sll $0,$0,0
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0000;

  // Busy-vector layout from the mul/div unit, so each stage can name the bits it waits on
  localparam logic [BUSY_W_DEF-1:0] BUSY_MUL    = 3'b001;
  localparam logic [BUSY_W_DEF-1:0] BUSY_DIV    = 3'b010;
  localparam logic [BUSY_W_DEF-1:0] BUSY_WB     = 3'b100;
  localparam logic [BUSY_W_DEF-1:0] BUSY_MULDIV = BUSY_MUL | BUSY_DIV;
  localparam logic [BUSY_W_DEF-1:0] BUSY_ALL    = BUSY_MULDIV | BUSY_WB;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } stage_act_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg_ctl.sv
// Pipeline stage register with valid, flush, bubble insertion, masked busy hold
// and saturating stall/bubble/flush event counters.
module pipe_stage_reg_ctl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        WIDTH     = INSN_W,
  parameter int unsigned        BUSY_W    = BUSY_W_DEF,
  parameter logic [BUSY_W-1:0]  BUSY_MASK = {BUSY_W{1'b1}},
  parameter logic [WIDTH-1:0]   NOP_VALUE = WIDTH'(NOP_INSN),
  parameter int unsigned        CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              bubble,
  input  logic              flush,
  input  logic [BUSY_W-1:0] busy,
  input  logic              cnt_clr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic              hold,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic             busy_hold_c;
  stage_act_e       act_c;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  assign busy_hold_c = |(busy & BUSY_MASK);
  assign hold        = (stall | busy_hold_c) & ~flush;

  // Edge action, flush > hold > bubble > load
  always_comb begin
    act_c = ACT_LOAD;
    if (flush) begin
      act_c = ACT_FLUSH;
    end else if (hold) begin
      act_c = ACT_HOLD;
    end else if (bubble) begin
      act_c = ACT_BUBBLE;
    end
  end

  always_comb begin
    data_d  = in_data;
    valid_d = in_valid;
    case (act_c)
      ACT_FLUSH, ACT_BUBBLE: begin
        data_d  = NOP_VALUE;
        valid_d = 1'b0;
      end
      ACT_HOLD: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      default: begin
        data_d  = in_data;
        valid_d = in_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= NOP_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (act_c == ACT_HOLD),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (act_c == ACT_BUBBLE),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (act_c == ACT_FLUSH),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg_ctl.sv
// Scoreboard bench: stage A (mask WB, 4-bit counters) and stage B (mask mul|div, custom NOP)
// share all inputs; each cycle's expected outputs are queued at drive time and popped after the edge.
module tb_pipe_stage_reg_ctl;
  import cpu_pipe_pkg::*;

  localparam logic [31:0] NOP_B = 32'hC0DE_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, stall, bubble, flush, cnt_clr;
  logic [2:0]  busy;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_hold, b_hold;
  logic [3:0]  a_sc, a_bc, a_fc;
  logic [15:0] b_sc, b_bc, b_fc;

  always #5 clk = ~clk;

  pipe_stage_reg_ctl #(
    .WIDTH(32), .BUSY_W(3), .BUSY_MASK(BUSY_WB), .NOP_VALUE(NOP_INSN), .CNT_W(4)
  ) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .bubble(bubble), .flush(flush), .busy(busy), .cnt_clr(cnt_clr),
    .out_data(a_data), .out_valid(a_valid), .hold(a_hold),
    .stall_cnt(a_sc), .bubble_cnt(a_bc), .flush_cnt(a_fc)
  );

  pipe_stage_reg_ctl #(
    .BUSY_MASK(BUSY_MULDIV), .NOP_VALUE(NOP_B)
  ) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .bubble(bubble), .flush(flush), .busy(busy), .cnt_clr(cnt_clr),
    .out_data(b_data), .out_valid(b_valid), .hold(b_hold),
    .stall_cnt(b_sc), .bubble_cnt(b_bc), .flush_cnt(b_fc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        hold;
    logic [3:0]  sc;
    logic [3:0]  bc;
    logic [3:0]  fc;
    logic [31:0] bdata;
    logic        bvalid;
    logic        bhold;
    logic [15:0] bsc;
    logic [15:0] bbc;
    logic [15:0] bfc;
  } exp_t;

  typedef struct packed {
    logic [31:0] d;
    logic        v, st, bu, fl;
    logic [2:0]  bz;
    logic        clr, rst;
  } stim_t;

  exp_t sb_q[$];
  exp_t obs;
  int   n_vec = 0;
  int   n_err = 0;

  assign obs = {a_data, a_valid, a_hold, a_sc, a_bc, a_fc,
                b_data, b_valid, b_hold, b_sc, b_bc, b_fc};

  // Reference model state
  logic [31:0] m_data, mb_data;
  logic        m_valid, mb_valid;
  logic [3:0]  m_sc, m_bc, m_fc;
  logic [15:0] mb_sc, mb_bc, mb_fc;

  function automatic stim_t mk(input logic [31:0] d, input logic v, st, bu, fl,
                               input logic [2:0] bz, input logic clr, rst);
    stim_t s;
    s.d = d; s.v = v; s.st = st; s.bu = bu; s.fl = fl; s.bz = bz; s.clr = clr; s.rst = rst;
    return s;
  endfunction

  // Apply one cycle of stimulus, advance the model, queue the expectation, step past the edge
  task automatic drive(input stim_t s);
    logic ha, hb;
    exp_t e;
    reset = s.rst; in_data = s.d; in_valid = s.v; stall = s.st;
    bubble = s.bu; flush = s.fl; busy = s.bz; cnt_clr = s.clr;
    ha = (s.st | s.bz[2]) & ~s.fl;
    hb = (s.st | s.bz[1] | s.bz[0]) & ~s.fl;
    if (s.rst) begin
      m_data = NOP_INSN; m_valid = 1'b0; m_sc = '0; m_bc = '0; m_fc = '0;
      mb_data = NOP_B; mb_valid = 1'b0; mb_sc = '0; mb_bc = '0; mb_fc = '0;
    end else begin
      if (s.clr) begin
        m_sc = '0; m_bc = '0; m_fc = '0; mb_sc = '0; mb_bc = '0; mb_fc = '0;
      end else begin
        if (s.fl && m_fc != 4'hF) m_fc = m_fc + 4'd1;
        if (ha && m_sc != 4'hF) m_sc = m_sc + 4'd1;
        if (!s.fl && !ha && s.bu && m_bc != 4'hF) m_bc = m_bc + 4'd1;
        if (s.fl && mb_fc != 16'hFFFF) mb_fc = mb_fc + 16'd1;
        if (hb && mb_sc != 16'hFFFF) mb_sc = mb_sc + 16'd1;
        if (!s.fl && !hb && s.bu && mb_bc != 16'hFFFF) mb_bc = mb_bc + 16'd1;
      end
      if (s.fl || (!ha && s.bu)) begin
        m_data = NOP_INSN; m_valid = 1'b0;
      end else if (!ha) begin
        m_data = s.d; m_valid = s.v;
      end
      if (s.fl || (!hb && s.bu)) begin
        mb_data = NOP_B; mb_valid = 1'b0;
      end else if (!hb) begin
        mb_data = s.d; mb_valid = s.v;
      end
    end
    e = {m_data, m_valid, ha, m_sc, m_bc, m_fc, mb_data, mb_valid, hb, mb_sc, mb_bc, mb_fc};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'h1234_5678, 1, 0, 0, 0, 3'b000, 0, 1));
    seq.push_back(mk(32'h1234_5678, 1, 0, 0, 0, 3'b000, 0, 1));
    seq.push_back(mk(32'h1234_5678, 1, 0, 0, 0, 3'b000, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h exp %h", i, obs, e);
      end
      if (i < 2) begin
        n_vec++;
        if ({a_data, a_valid, a_sc, a_bc, a_fc} !== {NOP_INSN, 1'b0, 12'h000}) begin
          n_err++;
          $display("FAIL reset_state: got data=%h valid=%b cnt=%h/%h/%h exp NOP, 0, 0",
                   a_data, a_valid, a_sc, a_bc, a_fc);
        end
      end
    end
    n_vec++;
    if (a_data !== 32'h1234_5678 || a_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got %h/%b exp 12345678/1", a_data, a_valid);
    end
  endtask

  task automatic test_stall();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'hAAAA_0001, 1, 0, 0, 0, 3'b000, 1, 0));
    for (int k = 0; k < 3; k++) seq.push_back(mk(32'hBBBB_0002, 1, 1, 0, 0, 3'b000, 0, 0));
    seq.push_back(mk(32'hBBBB_0002, 1, 0, 0, 0, 3'b000, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h exp %h", i, obs, e);
      end
      if (i == 3) begin
        n_vec++;
        if (a_data !== 32'hAAAA_0001 || a_sc !== 4'd3 || a_hold !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold: got data=%h sc=%0d hold=%b exp AAAA0001/3/1", a_data, a_sc, a_hold);
        end
      end
    end
    n_vec++;
    if (a_data !== 32'hBBBB_0002) begin
      n_err++;
      $display("FAIL stall_release: got %h exp BBBB0002", a_data);
    end
  endtask

  task automatic test_busy();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'h0000_0100, 1, 0, 0, 0, 3'b000, 1, 0));
    for (int k = 1; k <= 4; k++) seq.push_back(mk(32'h0000_0100 + 32'(k), 1, 0, 0, 0, 3'b100, 0, 0));
    seq.push_back(mk(32'h0000_0105, 1, 0, 0, 0, 3'b001, 0, 0));
    seq.push_back(mk(32'h0000_0106, 1, 0, 0, 0, 3'b010, 0, 0));
    seq.push_back(mk(32'h0000_0107, 1, 0, 0, 0, 3'b000, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL busy[%0d]: got %h exp %h", i, obs, e);
      end
      if (i == 4) begin
        n_vec++;
        if (a_sc !== 4'd4 || a_data !== 32'h100 || b_data !== 32'h104 || b_sc !== 16'd0) begin
          n_err++;
          $display("FAIL busy_mask: got a_sc=%0d a=%h b=%h b_sc=%0d exp 4/100/104/0",
                   a_sc, a_data, b_data, b_sc);
        end
      end
    end
  endtask

  task automatic test_flush_bubble();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'h0000_0077, 1, 0, 0, 0, 3'b000, 1, 0));
    seq.push_back(mk(32'h0000_0088, 1, 1, 1, 1, 3'b111, 0, 0));
    seq.push_back(mk(32'h0000_0099, 1, 0, 1, 0, 3'b000, 0, 0));
    seq.push_back(mk(32'h0000_0055, 0, 0, 0, 0, 3'b000, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL flush_bubble[%0d]: got %h exp %h", i, obs, e);
      end
    end
    n_vec++;
    if (a_data !== 32'h55 || a_valid !== 1'b0 || {a_sc, a_bc, a_fc} !== 12'h011) begin
      n_err++;
      $display("FAIL flush_bubble_end: got %h/%b cnt=%h%h%h exp 55/0 cnt=011",
               a_data, a_valid, a_sc, a_bc, a_fc);
    end
  endtask

  task automatic test_saturate();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'h0000_0001, 1, 0, 0, 0, 3'b000, 1, 0));
    for (int k = 0; k < 20; k++) seq.push_back(mk(32'h0000_0002, 1, 1, 0, 0, 3'b000, 0, 0));
    seq.push_back(mk(32'h0000_0002, 1, 1, 0, 0, 3'b000, 1, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL saturate[%0d]: got %h exp %h", i, obs, e);
      end
      if (i == 20) begin
        n_vec++;
        if (a_sc !== 4'hF || b_sc !== 16'd20) begin
          n_err++;
          $display("FAIL saturate_top: got a_sc=%0d b_sc=%0d exp 15/20", a_sc, b_sc);
        end
      end
    end
    n_vec++;
    if (a_sc !== 4'd0 || b_sc !== 16'd0 || a_data !== 32'h1) begin
      n_err++;
      $display("FAIL clr_vs_inc: got a_sc=%0d b_sc=%0d data=%h exp 0/0/1", a_sc, b_sc, a_data);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(32'hDEAD_BEEF, 1, 0, 0, 0, 3'b000, 0, 0));
    seq.push_back(mk(32'h0000_0003, 1, 1, 0, 0, 3'b000, 0, 0));
    seq.push_back(mk(32'h0000_0003, 1, 1, 0, 0, 3'b100, 0, 0));
    seq.push_back(mk(32'h0000_0003, 1, 1, 0, 0, 3'b100, 0, 1));
    seq.push_back(mk(32'h0000_0004, 1, 0, 0, 0, 3'b000, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid_stall[%0d]: got %h exp %h", i, obs, e);
      end
      if (i == 3) begin
        n_vec++;
        if (a_data !== NOP_INSN || a_valid !== 1'b0 || {a_sc, a_bc, a_fc} !== 12'h000 || b_data !== NOP_B) begin
          n_err++;
          $display("FAIL reset_wins: got a=%h/%b cnt=%h%h%h b=%h exp NOP/0/000/%h",
                   a_data, a_valid, a_sc, a_bc, a_fc, b_data, NOP_B);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 300; i++) begin
      s = mk($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 3'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      drive(s);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL random[%0d]: got %h exp %h", i, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; stall = 1'b0; bubble = 1'b0;
    flush = 1'b0; busy = '0; cnt_clr = 1'b0;
    m_data = NOP_INSN; m_valid = 1'b0; m_sc = '0; m_bc = '0; m_fc = '0;
    mb_data = NOP_B; mb_valid = 1'b0; mb_sc = '0; mb_bc = '0; mb_fc = '0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_busy();
    test_flush_bubble();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
